// File: rtl/alu_dsub_seq_if.sv
// Handshake and data bundle between the execute stage and the
// digit-serial BCD subtractor.
interface alu_dsub_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        invalid;
  logic [15:0] psw_out;
  logic [15:0] psw_msk;

  // Execute-stage side: issues operands and start, observes status/result.
  modport master (
    output start, a, b, carry_in,
    input  busy, done, result, invalid, psw_out, psw_msk
  );

  // Subtractor side.
  modport slave (
    input  start, a, b, carry_in,
    output busy, done, result, invalid, psw_out, psw_msk
  );
endinterface

// File: rtl/alu_dsub_seq.sv
// Digit-serial packed-BCD subtractor: result = a - b - (1 - carry_in),
// one digit per clock, least-significant digit first, using the
// nines-complement of each subtrahend digit plus a rippling not-borrow.
module alu_dsub_seq #(
  parameter int NDIG = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_dsub_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] LAST_DIG = 2'(NDIG - 1);

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] result_q, result_d;
  logic [15:0] psw_q, psw_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic        invalid_q, invalid_d;

  // Per-digit datapath signals
  logic [3:0]  a_dig, b_dig, nc, dig;
  logic [4:0]  s, s_adj;
  logic        carry_out;
  logic        dig_bad;

  // Single-digit nines-complement add of the digit selected by cnt_q.
  always_comb begin
    a_dig     = a_q[{cnt_q, 2'b00} +: 4];
    b_dig     = b_q[{cnt_q, 2'b00} +: 4];
    nc        = 4'd9 - b_dig;            // wraps mod 16 for non-BCD b digits
    s         = {1'b0, a_dig} + {1'b0, nc} + {4'd0, carry_q};
    s_adj     = s - 5'd10;
    dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
    if (s > 5'd9) begin
      dig       = s_adj[3:0];
      carry_out = 1'b1;
    end else begin
      dig       = s[3:0];
      carry_out = 1'b0;
    end
  end

  // Next-state and register-update logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    psw_d     = psw_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    invalid_d = invalid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          carry_d   = bus.carry_in;
          cnt_d     = 2'd0;
          invalid_d = 1'b0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        result_d[{cnt_q, 2'b00} +: 4] = dig;
        carry_d   = carry_out;
        invalid_d = invalid_q | dig_bad;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == LAST_DIG) begin
          // Flags use the fully assembled result, including this last digit.
          psw_d   = {11'd0, 1'b0, 1'b0, result_d[15], (result_d == 16'h0000), carry_out};
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      result_q  <= 16'h0000;
      psw_q     <= 16'h0000;
      cnt_q     <= 2'd0;
      carry_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      psw_q     <= psw_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.result  = result_q;
  assign bus.invalid = invalid_q;
  assign bus.psw_out = psw_q;
  assign bus.psw_msk = 16'h0017;

endmodule

// File: tb/tb_alu_dsub_seq.sv
// Self-checking bench for the digit-serial BCD subtractor: directed cases
// followed by random valid-BCD operations checked against a decimal model.
module tb_alu_dsub_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_dsub_seq_if bus ();

  alu_dsub_seq #(.NDIG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decimal value of a valid packed-BCD word.
  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    logic [15:0] r = 16'h0000;
    int t = x;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal subtraction modulo 10000, carry = no borrow.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output logic [15:0] res, output logic c);
    int d;
    d = bcd2int(a) - bcd2int(b) - (cin ? 0 : 1);
    c = (d >= 0);
    if (d < 0) d += 10000;
    res = int2bcd(d);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // One full operation: start, scramble inputs after acceptance, optionally
  // pulse start again while busy, then check timing, result and flags.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input int poke,
                        input logic [15:0] exp_res, input logic exp_c, input logic exp_inv);
    int lat;
    int extra_done;
    logic [15:0] exp_psw;
    exp_psw = {11'd0, 1'b0, 1'b0, exp_res[15], (exp_res == 16'h0000), exp_c};

    @(negedge clk);
    bus.start    = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    @(posedge clk);                      // acceptance edge
    @(negedge clk);
    bus.start    = 1'b0;
    bus.a        = 16'($urandom);        // must not affect the running op
    bus.b        = 16'($urandom);
    bus.carry_in = 1'($urandom);
    check({tag, "_busy_after_start"}, {15'd0, bus.busy}, 16'd1);

    lat = 1;
    while (!bus.done && lat < 20) begin
      bus.start = (lat == poke);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 16'(lat), 16'd5);
    check({tag, "_busy_at_done"}, {15'd0, bus.busy}, 16'd1);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_invalid"}, {15'd0, bus.invalid}, {15'd0, exp_inv});
    check({tag, "_psw"}, bus.psw_out, exp_psw);
    check({tag, "_msk"}, bus.psw_msk, 16'h0017);

    @(negedge clk);
    check({tag, "_done_drop"}, {14'd0, bus.busy, bus.done}, 16'd0);
    check({tag, "_result_hold"}, bus.result, exp_res);

    extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check({tag, "_single_done"}, 16'(extra_done), 16'd0);
  endtask

  initial begin
    logic [15:0] ra, rb, rres;
    logic        rcin, rc;

    bus.start    = 1'b0;
    bus.a        = 16'h0000;
    bus.b        = 16'h0000;
    bus.carry_in = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);
    check("reset_result", bus.result, 16'h0000);
    check("reset_invalid", {15'd0, bus.invalid}, 16'd0);
    check("reset_psw", bus.psw_out, 16'h0000);

    run_op("basic",    16'h1234, 16'h0234, 1'b1, 0, 16'h1000, 1'b1, 1'b0);
    run_op("wrap",     16'h0000, 16'h0001, 1'b1, 0, 16'h9999, 1'b0, 1'b0);
    run_op("zero",     16'h5555, 16'h5555, 1'b1, 0, 16'h0000, 1'b1, 1'b0);
    run_op("zero_cin0",16'h5555, 16'h5555, 1'b0, 0, 16'h9999, 1'b0, 1'b0);
    run_op("chain",    16'h1000, 16'h0001, 1'b1, 0, 16'h0999, 1'b1, 1'b0);
    run_op("nonbcd",   16'h00A0, 16'h0000, 1'b1, 0, 16'h00A0, 1'b1, 1'b1);
    run_op("valid_again", 16'h0042, 16'h0017, 1'b1, 0, 16'h0025, 1'b1, 1'b0);
    run_op("start_ignored", 16'h9876, 16'h1234, 1'b1, 2, 16'h8642, 1'b1, 1'b0);

    // Abort an operation with reset two cycles after acceptance.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.a        = 16'h4321;
    bus.b        = 16'h1111;
    bus.carry_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);
    check("abort_result", bus.result, 16'h0000);
    check("abort_psw", bus.psw_out, 16'h0000);
    run_op("after_abort", 16'h0042, 16'h0017, 1'b1, 0, 16'h0025, 1'b1, 1'b0);

    for (int n = 0; n < 25; n++) begin
      ra   = rand_bcd();
      rb   = rand_bcd();
      rcin = 1'($urandom);
      model(ra, rb, rcin, rres, rc);
      run_op($sformatf("rand%0d", n), ra, rb, rcin, 0, rres, rc, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_dsub_seq.md
Name: alu_dsub_seq

Overview:
- Digit-serial packed-BCD subtractor for the XM23 ALU. It is the subtract-direction counterpart of the combinational BCD adder.
- Computes result = a − b − (1 − carry_in) over 4 BCD digits, one digit per clock, least-significant digit first. Uses the nines-complement method.
- Driven by the execute stage through a start/busy/done handshake. Returns a 16-bit result plus PSW flag value and mask in the same format as the other ALU units.

Parameters:
- NDIG, 4, number of BCD digits processed. Fixed at 4 for the 16-bit datapath; no other values are supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  16  minuend, packed BCD, a[3:0] = digit 0.
- b  in  16  subtrahend, packed BCD.
- carry_in  in  1  not-borrow in (1 = no incoming borrow).
- busy  out  1  high from the cycle after start is accepted until done drops.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  16  packed BCD difference.
- invalid  out  1  a non-BCD digit (>9) was seen in a or b.
- psw_out  out  16  bit0 C, bit1 Z, bit2 N, bit4 V; all other bits 0.
- psw_msk  out  16  constant 16'h0017.

Behaviour:
- Reset: synchronous, active-high on rst.
  - State returns to IDLE.
  - busy=0, done=0, result=0, invalid=0, psw_out=0.
  - Digit counter and carry are cleared.
  - rst asserted mid-operation aborts the operation; the next cycle is IDLE with all outputs zero.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: if start=1 at edge E0, latch a, b, carry_in into internal registers, set carry=carry_in, set cnt=0, clear the invalid accumulator, go to RUN. busy=1 after E0.
  - RUN: on each edge, process digit cnt, then increment cnt. After the edge processing cnt=NDIG−1 (edge E4), go to DONE.
  - DONE: done=1 for exactly one cycle (the cycle after E4); busy stays 1 in that cycle. Next edge goes to IDLE with busy=0 and done=0.
- Latency: done is high 5 cycles after the start edge. The earliest next start is sampled on the edge that leaves DONE+1, i.e. in IDLE. Throughput is one operation per 6 cycles.
- start while busy (RUN/DONE) is ignored. Input changes after E0 have no effect.
- Per-digit arithmetic, for digit i:
  - nc = (4'd9 − b_i) mod 16.
  - s = a_i + nc + carry, computed at 5-bit width.
  - If s > 9: digit = (s − 10)[3:0] and carry = 1.
  - Otherwise: digit = s[3:0] and carry = 0.
  - Each digit is written into the result shift/slot register.
- invalid is set if any a_i > 9 or b_i > 9. The arithmetic still follows the rule above, so the result is deterministic.
- Flags are computed when DONE is entered:
  - C = final carry (1 = no borrow).
  - Z = (result == 0).
  - N = result[15].
  - V = 0.
- result, invalid and psw_out hold their values from DONE until the next accepted start. At the next start they hold until overwritten during RUN; a bench must sample them only when done=1.
- carry_in=1 gives a true a−b. carry_in=0 subtracts an additional 1.
- Wrap-around: a negative difference yields the ten's complement, e.g. 0000−0001 = 9999 with C=0.

Test Plan:
- a=16'h1234, b=16'h0234, carry_in=1, start pulse -> done exactly 5 cycles later; result=16'h1000, C=1, Z=0, N=0, invalid=0, psw_msk=16'h0017.
- a=16'h0000, b=16'h0001, carry_in=1 -> result=16'h9999, C=0, N=1, Z=0; borrow ripples through all 4 digits.
- a=16'h5555, b=16'h5555, carry_in=1 -> result=16'h0000, Z=1, C=1. Repeat with carry_in=0 -> result=16'h9999, C=0, Z=0.
- a=16'h1000, b=16'h0001, carry_in=1 -> result=16'h0999, C=1 (borrow chain from digit 0 to digit 3).
- a=16'h00A0, b=16'h0000, carry_in=1 -> invalid=1, result=16'h00A0, C=1. Next operation with valid digits -> invalid=0.
- Start an operation; assert start again at cycle 2 -> ignored, single done pulse. Then start a new operation and assert rst at cycle 2 -> next cycle busy=0, done=0, result=0. A following op, a=16'h0042, b=16'h0017, carry_in=1 -> result=16'h0025, C=1.
